mix_columns_sched: RTL

- Sequences one shared 32-bit combinational MixColumn datapath (ports A, B, enc_dec) across the four columns of a 128-bit AES state, one column per clock.
- Sits in the cipher unit between ShiftRows/InvShiftRows and AddRoundKey.
- Uses valid/ready handshakes on both sides.
- Supports a bypass for the final round, where MixColumns is skipped.

---
 rtl/mix_columns_sched.sv | 77 +++++++
 1 files changed

// File: rtl/mix_columns_sched.sv
// mix_columns_sched: runs one shared 32-bit MixColumn datapath over the four
// columns of a 128-bit AES state, one column per clock, with a final-round bypass.
module mix_columns_sched #(
  parameter int COL_W = 32,
  parameter int NUM_COLS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COL_W*NUM_COLS-1:0] in_state,
  input  logic                      in_enc_dec,
  input  logic                      in_bypass,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COL_W*NUM_COLS-1:0] out_state,
  output logic [COL_W-1:0]          mc_a,
  output logic                      mc_enc_dec,
  input  logic [COL_W-1:0]          mc_b,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [COL_W*NUM_COLS-1:0] work;
  logic [1:0] col_idx;
  logic enc_dec;
  logic accept;
  logic [6:0] col_lsb;
  // column 0 lives in the top bits, so the slice offset is (3 - col_idx) * 32
  assign col_lsb = {~col_idx, 5'd0};
  assign accept = (state == IDLE) && in_valid;
  assign out_state = out_valid ? work : '0;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      col_idx <= 2'd0;
      enc_dec <= 1'b0;
    end else if (accept) begin
      work <= in_state;
      enc_dec <= in_enc_dec;
      col_idx <= 2'd0;
    end else if (state == RUN) begin
      work[col_lsb +: COL_W] <= mc_b;
      col_idx <= col_idx + 2'd1;
    end
  end
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    busy = 1'b0;
    mc_a = '0;
    mc_enc_dec = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = in_bypass ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        mc_a = work[col_lsb +: COL_W];
        mc_enc_dec = enc_dec;
        if (col_idx == 2'd3) state_nx = DONE;
      end
      DONE: begin
        busy = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
